// File: rtl/rename_pkg.sv
// Shared types and width helpers for the rename group.
// Optional feature macro: RENAME_ZERO_REG_EN (hard-wires logical x0 to preg 0).
package rename_pkg;

    // Opaque decode bundle (pc, imm, types) carried alongside each lane.
    localparam int PAYLOAD_W  = 32;
    // Upper bounds for the per-lane output record; covers up to 256 pregs / 64 lregs.
    localparam int PREG_W_MAX = 8;
    localparam int LREG_W_MAX = 6;

    typedef logic [PAYLOAD_W-1:0] payload_t;

    // One renamed lane as held in the output pipeline register.
    typedef struct packed {
        logic [LREG_W_MAX-1:0] lrd;
        logic [PREG_W_MAX-1:0] prs1;
        logic [PREG_W_MAX-1:0] prs2;
        logic [PREG_W_MAX-1:0] prd;
        logic [PREG_W_MAX-1:0] old_prd;
        payload_t              payload;
    } lane_out_t;

    function automatic int preg_w(input int preg_num);
        return (preg_num > 1) ? $clog2(preg_num) : 1;
    endfunction

    function automatic int lreg_w(input int lreg_num);
        return (lreg_num > 1) ? $clog2(lreg_num) : 1;
    endfunction

endpackage

// File: rtl/rename_dep_check.sv
// Intra-group dependency check for one lane: picks the youngest older
// allocating lane whose destination matches a source (RAW) or this lane's
// destination (WAW), falling back to the speculative RAT value.
module rename_dep_check
    import rename_pkg::*;
#(
    parameter int LANES  = 2,
    parameter int LREG_W = 5,
    parameter int PREG_W = 6,
    parameter int IDX    = 0
) (
    input  logic [LREG_W-1:0]       lrs1,
    input  logic [LREG_W-1:0]       lrs2,
    input  logic [LREG_W-1:0]       lrd,
    input  logic                    src1_is_reg,
    input  logic                    src2_is_reg,
    input  logic [LANES-1:0]        lane_alloc,
    input  logic [LANES*LREG_W-1:0] lane_lrd,
    input  logic [LANES*PREG_W-1:0] lane_prd,
    input  logic [PREG_W-1:0]       rat_rs1,
    input  logic [PREG_W-1:0]       rat_rs2,
    input  logic [PREG_W-1:0]       rat_rd,
    output logic [PREG_W-1:0]       prs1,
    output logic [PREG_W-1:0]       prs2,
    output logic [PREG_W-1:0]       old_prd
);

    // Only lanes older than IDX are inspected; the sink keeps the rest lint-quiet.
    logic unused_lanes;
    assign unused_lanes = ^{lane_alloc, lane_lrd, lane_prd};

    // Scan older lanes oldest-first so the youngest match overrides earlier ones.
    always_comb begin
        prs1    = rat_rs1;
        prs2    = rat_rs2;
        old_prd = rat_rd;
        for (int j = 0; j < IDX; j++) begin
            if (lane_alloc[j]) begin
                if (src1_is_reg && (lane_lrd[j*LREG_W +: LREG_W] == lrs1))
                    prs1 = lane_prd[j*PREG_W +: PREG_W];
                if (src2_is_reg && (lane_lrd[j*LREG_W +: LREG_W] == lrs2))
                    prs2 = lane_prd[j*PREG_W +: PREG_W];
                if (lane_lrd[j*LREG_W +: LREG_W] == lrd)
                    old_prd = lane_prd[j*PREG_W +: PREG_W];
            end
        end
    end

endmodule

// File: rtl/rename_group.sv
// Register rename for one group of LANES instructions: freelist allocation,
// intra-group bypass, speculative and architectural RATs, one-cycle output
// register with stall/flush. Optional macro: RENAME_ZERO_REG_EN.
module rename_group
    import rename_pkg::*;
#(
    parameter  int LANES    = 2,
    parameter  int PREG_NUM = 64,
    parameter  int LREG_NUM = 32,
    localparam int PREG_W   = preg_w(PREG_NUM),
    localparam int LREG_W   = lreg_w(LREG_NUM),
    localparam int CNT_W    = $clog2(LANES + 1)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [LANES-1:0]           in_valid,
    output logic                       in_ready,
    input  logic [LANES*LREG_W-1:0]    in_lrs1,
    input  logic [LANES*LREG_W-1:0]    in_lrs2,
    input  logic [LANES*LREG_W-1:0]    in_lrd,
    input  logic [LANES-1:0]           in_src1_is_reg,
    input  logic [LANES-1:0]           in_src2_is_reg,
    input  logic [LANES-1:0]           in_need_to_wb,
    input  logic [LANES*PAYLOAD_W-1:0] in_payload,
    input  logic [CNT_W-1:0]           fl_avail,
    input  logic [LANES*PREG_W-1:0]    fl_preg,
    output logic [CNT_W-1:0]           fl_pop,
    input  logic [LANES-1:0]           cm_valid,
    input  logic [LANES*LREG_W-1:0]    cm_lrd,
    input  logic [LANES*PREG_W-1:0]    cm_prd,
    input  logic                       flush_valid,
    output logic [LANES-1:0]           out_valid,
    input  logic                       out_ready,
    output logic [LANES*PREG_W-1:0]    out_prs1,
    output logic [LANES*PREG_W-1:0]    out_prs2,
    output logic [LANES*PREG_W-1:0]    out_prd,
    output logic [LANES*PREG_W-1:0]    out_old_prd,
    output logic [LANES*LREG_W-1:0]    out_lrd,
    output logic [LANES*PAYLOAD_W-1:0] out_payload
);

    logic [LANES-1:0]        alloc;
    logic [CNT_W-1:0]        need;
    logic                    accept;
    logic [PREG_W-1:0]       prd [LANES];
    logic [LANES*PREG_W-1:0] prd_flat;
    lane_out_t               lane_next [LANES];

    logic [PREG_W-1:0]       spec_rat_reg  [LREG_NUM];
    logic [PREG_W-1:0]       arch_rat_reg  [LREG_NUM];
    logic [PREG_W-1:0]       arch_rat_next [LREG_NUM];
    lane_out_t               out_reg       [LANES];
    logic [LANES-1:0]        out_valid_reg;

    // Hand out freelist entries in lane order; the running count is the slot index.
    always_comb begin
        int slot;
        slot = 0;
        for (int i = 0; i < LANES; i++) begin
            prd[i] = '0;
            if (alloc[i])
                prd[i] = fl_preg[slot*PREG_W +: PREG_W];
            slot = slot + int'(alloc[i]);
        end
        need = CNT_W'(slot);
    end

    // Whole-group handshake: stall on full output, short freelist, flush or reset.
    always_comb begin
        in_ready = ~reset & ~flush_valid & (~|out_valid_reg | out_ready) & (fl_avail >= need);
        accept   = in_ready & in_valid[0];
        fl_pop   = accept ? need : '0;
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [LREG_W-1:0] lrs1;
        logic [LREG_W-1:0] lrs2;
        logic [LREG_W-1:0] lrd;
        logic [PREG_W-1:0] dep_prs1;
        logic [PREG_W-1:0] dep_prs2;
        logic [PREG_W-1:0] dep_old_prd;
        logic [PREG_W-1:0] prs1;
        logic [PREG_W-1:0] prs2;
        logic              unused_hi;

        assign lrs1 = in_lrs1[gi*LREG_W +: LREG_W];
        assign lrs2 = in_lrs2[gi*LREG_W +: LREG_W];
        assign lrd  = in_lrd[gi*LREG_W +: LREG_W];

`ifdef RENAME_ZERO_REG_EN
        assign alloc[gi] = in_valid[gi] & in_need_to_wb[gi] & (lrd != '0);
`else
        assign alloc[gi] = in_valid[gi] & in_need_to_wb[gi];
`endif
        assign prd_flat[gi*PREG_W +: PREG_W] = prd[gi];

        rename_dep_check #(
            .LANES  (LANES),
            .LREG_W (LREG_W),
            .PREG_W (PREG_W),
            .IDX    (gi)
        ) u_dep_check (
            .lrs1        (lrs1),
            .lrs2        (lrs2),
            .lrd         (lrd),
            .src1_is_reg (in_src1_is_reg[gi]),
            .src2_is_reg (in_src2_is_reg[gi]),
            .lane_alloc  (alloc),
            .lane_lrd    (in_lrd),
            .lane_prd    (prd_flat),
            .rat_rs1     (spec_rat_reg[lrs1]),
            .rat_rs2     (spec_rat_reg[lrs2]),
            .rat_rd      (spec_rat_reg[lrd]),
            .prs1        (dep_prs1),
            .prs2        (dep_prs2),
            .old_prd     (dep_old_prd)
        );

`ifdef RENAME_ZERO_REG_EN
        assign prs1 = (lrs1 == '0) ? '0 : dep_prs1;
        assign prs2 = (lrs2 == '0) ? '0 : dep_prs2;
`else
        assign prs1 = dep_prs1;
        assign prs2 = dep_prs2;
`endif

        assign lane_next[gi].lrd     = LREG_W_MAX'(lrd);
        assign lane_next[gi].prs1    = PREG_W_MAX'(prs1);
        assign lane_next[gi].prs2    = PREG_W_MAX'(prs2);
        assign lane_next[gi].prd     = PREG_W_MAX'(prd[gi]);
        assign lane_next[gi].old_prd = PREG_W_MAX'(dep_old_prd);
        assign lane_next[gi].payload = in_payload[gi*PAYLOAD_W +: PAYLOAD_W];

        assign out_prs1[gi*PREG_W +: PREG_W]       = out_reg[gi].prs1[PREG_W-1:0];
        assign out_prs2[gi*PREG_W +: PREG_W]       = out_reg[gi].prs2[PREG_W-1:0];
        assign out_prd[gi*PREG_W +: PREG_W]        = out_reg[gi].prd[PREG_W-1:0];
        assign out_old_prd[gi*PREG_W +: PREG_W]    = out_reg[gi].old_prd[PREG_W-1:0];
        assign out_lrd[gi*LREG_W +: LREG_W]        = out_reg[gi].lrd[LREG_W-1:0];
        assign out_payload[gi*PAYLOAD_W +: PAYLOAD_W] = out_reg[gi].payload;
        // Upper record bits beyond the configured widths are always zero.
        assign unused_hi = ^out_reg[gi];
    end

    assign out_valid = out_valid_reg;

    // Architectural RAT next state: commits applied in age order, youngest wins.
    always_comb begin
        arch_rat_next = arch_rat_reg;
        for (int i = 0; i < LANES; i++) begin
            if (cm_valid[i]) begin
`ifdef RENAME_ZERO_REG_EN
                if (cm_lrd[i*LREG_W +: LREG_W] != '0)
`endif
                arch_rat_next[cm_lrd[i*LREG_W +: LREG_W]] = cm_prd[i*PREG_W +: PREG_W];
            end
        end
    end

    // Architectural RAT register; commits land regardless of flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LREG_NUM; i++)
                arch_rat_reg[i] <= PREG_W'(i);
        end else begin
            arch_rat_reg <= arch_rat_next;
        end
    end

    // Speculative RAT: restored from the committed view on flush, else updated on accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LREG_NUM; i++)
                spec_rat_reg[i] <= PREG_W'(i);
        end else if (flush_valid) begin
            spec_rat_reg <= arch_rat_next;
        end else if (accept) begin
            for (int i = 0; i < LANES; i++)
                if (alloc[i])
                    spec_rat_reg[in_lrd[i*LREG_W +: LREG_W]] <= prd[i];
        end
    end

    // Output pipeline register: load on accept, drain on out_ready, clear on flush.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid_reg <= '0;
            for (int i = 0; i < LANES; i++)
                out_reg[i] <= '0;
        end else if (flush_valid) begin
            out_valid_reg <= '0;
        end else if (accept) begin
            out_valid_reg <= in_valid;
            for (int i = 0; i < LANES; i++)
                out_reg[i] <= lane_next[i];
        end else if (out_ready) begin
            out_valid_reg <= '0;
        end
    end

endmodule

// File: tb/tb_rename_group.sv
// Directed bench for rename_group (LANES=2, 64 pregs, 32 lregs).
// Covers both builds of RENAME_ZERO_REG_EN.
module tb_rename_group;

    logic        clock;
    logic        reset;
    logic [1:0]  in_valid;
    logic        in_ready;
    logic [9:0]  in_lrs1, in_lrs2, in_lrd;
    logic [1:0]  in_src1_is_reg, in_src2_is_reg, in_need_to_wb;
    logic [63:0] in_payload;
    logic [1:0]  fl_avail;
    logic [11:0] fl_preg;
    logic [1:0]  fl_pop;
    logic [1:0]  cm_valid;
    logic [9:0]  cm_lrd;
    logic [11:0] cm_prd;
    logic        flush_valid;
    logic [1:0]  out_valid;
    logic        out_ready;
    logic [11:0] out_prs1, out_prs2, out_prd, out_old_prd;
    logic [9:0]  out_lrd;
    logic [63:0] out_payload;

    int tests_run    = 0;
    int tests_failed = 0;

    rename_group #(.LANES(2), .PREG_NUM(64), .LREG_NUM(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_lrs1        (in_lrs1),
        .in_lrs2        (in_lrs2),
        .in_lrd         (in_lrd),
        .in_src1_is_reg (in_src1_is_reg),
        .in_src2_is_reg (in_src2_is_reg),
        .in_need_to_wb  (in_need_to_wb),
        .in_payload     (in_payload),
        .fl_avail       (fl_avail),
        .fl_preg        (fl_preg),
        .fl_pop         (fl_pop),
        .cm_valid       (cm_valid),
        .cm_lrd         (cm_lrd),
        .cm_prd         (cm_prd),
        .flush_valid    (flush_valid),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_prs1       (out_prs1),
        .out_prs2       (out_prs2),
        .out_prd        (out_prd),
        .out_old_prd    (out_old_prd),
        .out_lrd        (out_lrd),
        .out_payload    (out_payload)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("[TB] ok   %s = %0d", tag, got);
        end
    endtask

    function automatic logic [31:0] p6(input logic [11:0] v, input int l);
        return 32'(v[l*6 +: 6]);
    endfunction

    function automatic logic [31:0] l5(input logic [9:0] v, input int l);
        return 32'(v[l*5 +: 5]);
    endfunction

    task automatic idle();
        in_valid       = '0;
        in_lrs1        = '0;
        in_lrs2        = '0;
        in_lrd         = '0;
        in_src1_is_reg = '0;
        in_src2_is_reg = '0;
        in_need_to_wb  = '0;
        in_payload     = '0;
        fl_avail       = 2'd2;
        fl_preg        = '0;
        cm_valid       = '0;
        cm_lrd         = '0;
        cm_prd         = '0;
        flush_valid    = 1'b0;
        out_ready      = 1'b1;
    endtask

    task automatic lane(input int l, input int rs1, input int rs2, input int rd,
                        input bit s1, input bit s2, input bit wb);
        in_valid[l]             = 1'b1;
        in_lrs1[l*5 +: 5]       = 5'(rs1);
        in_lrs2[l*5 +: 5]       = 5'(rs2);
        in_lrd[l*5 +: 5]        = 5'(rd);
        in_src1_is_reg[l]       = s1;
        in_src2_is_reg[l]       = s2;
        in_need_to_wb[l]        = wb;
        in_payload[l*32 +: 32]  = 32'hC0DE_0000 | 32'(rd * 16 + l);
    endtask

    task automatic pregs(input int p0, input int p1);
        fl_preg = {6'(p1), 6'(p0)};
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset asserted with a group presented
        reset = 1'b1;
        idle();
        lane(0, 1, 2, 3, 1, 1, 1);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_fl_pop", 32'(fl_pop), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_prd", 32'(out_prd), 32'd0);
        check("rst_out_payload", out_payload[31:0], 32'd0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Identity mapping after reset; non-register source reads the RAT
        idle();
        lane(0, 9, 10, 1, 1, 1, 0);
        lane(1, 31, 4, 2, 1, 0, 0);
        #1;
        check("id_in_ready", 32'(in_ready), 32'd1);
        check("id_fl_pop", 32'(fl_pop), 32'd0);
        tick();
        check("id_out_valid", 32'(out_valid), 32'd3);
        check("id_prs1_l0", p6(out_prs1, 0), 32'd9);
        check("id_prs2_l0", p6(out_prs2, 0), 32'd10);
        check("id_prs1_l1", p6(out_prs1, 1), 32'd31);
        check("id_prs2_l1", p6(out_prs2, 1), 32'd4);
        check("id_prd_l0", p6(out_prd, 0), 32'd0);
        check("id_old_l1", p6(out_old_prd, 1), 32'd2);
        check("id_lrd_l1", l5(out_lrd, 1), 32'd2);
        check("id_payload_l0", out_payload[31:0], 32'hC0DE_0010);
        check("id_payload_l1", out_payload[63:32], 32'hC0DE_0021);

        // RAW bypass: lane0 lrd=5 -> 40, lane1 reads x5
        idle();
        lane(0, 1, 2, 5, 1, 1, 1);
        lane(1, 5, 3, 6, 1, 1, 1);
        pregs(40, 41);
        #1;
        check("raw_in_ready", 32'(in_ready), 32'd1);
        check("raw_fl_pop", 32'(fl_pop), 32'd2);
        tick();
        check("raw_prd_l0", p6(out_prd, 0), 32'd40);
        check("raw_prd_l1", p6(out_prd, 1), 32'd41);
        check("raw_prs1_l1", p6(out_prs1, 1), 32'd40);
        check("raw_prs2_l1", p6(out_prs2, 1), 32'd3);
        check("raw_old_l0", p6(out_old_prd, 0), 32'd5);
        check("raw_old_l1", p6(out_old_prd, 1), 32'd6);

        // WAW on x7; sources read RAT[5]=40, RAT[6]=41; lane1 lrs2=7 bypasses 42
        idle();
        lane(0, 5, 6, 7, 1, 1, 1);
        lane(1, 6, 7, 7, 1, 1, 1);
        pregs(42, 43);
        tick();
        check("waw_old_l0", p6(out_old_prd, 0), 32'd7);
        check("waw_old_l1", p6(out_old_prd, 1), 32'd42);
        check("waw_prd_l1", p6(out_prd, 1), 32'd43);
        check("waw_rat5", p6(out_prs1, 0), 32'd40);
        check("waw_rat6", p6(out_prs2, 0), 32'd41);
        check("waw_prs2_l1", p6(out_prs2, 1), 32'd42);

        // RAT[7]=43; non-register sources ignore the bypass; single allocation
        idle();
        lane(0, 7, 7, 8, 1, 0, 1);
        lane(1, 8, 8, 9, 0, 1, 0);
        pregs(44, 45);
        #1;
        check("mix_fl_pop", 32'(fl_pop), 32'd1);
        tick();
        check("mix_prs1_l0", p6(out_prs1, 0), 32'd43);
        check("mix_prs2_l0", p6(out_prs2, 0), 32'd43);
        check("mix_prd_l0", p6(out_prd, 0), 32'd44);
        check("mix_prd_l1", p6(out_prd, 1), 32'd0);
        check("mix_prs1_l1", p6(out_prs1, 1), 32'd8);
        check("mix_prs2_l1", p6(out_prs2, 1), 32'd44);

        // Freelist short: need=2, fl_avail=1
        idle();
        lane(0, 0, 0, 10, 1, 1, 1);
        lane(1, 0, 0, 11, 1, 1, 1);
        fl_avail = 2'd1;
        #1;
        check("short_in_ready", 32'(in_ready), 32'd0);
        check("short_fl_pop", 32'(fl_pop), 32'd0);
        tick();
        check("short_out_valid", 32'(out_valid), 32'd0);
        idle();
        lane(0, 10, 11, 1, 1, 1, 0);
        tick();
        check("short_out_valid1", 32'(out_valid), 32'd1);
        check("short_rat10", p6(out_prs1, 0), 32'd10);
        check("short_rat11", p6(out_prs2, 0), 32'd11);

        // Backpressure: hold output for three cycles, then accept without a bubble
        idle();
        lane(0, 1, 1, 12, 1, 1, 1);
        pregs(46, 0);
        tick();
        check("bp_prd_l0", p6(out_prd, 0), 32'd46);
        idle();
        lane(0, 12, 1, 13, 1, 1, 1);
        pregs(47, 0);
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_fl_pop", 32'(fl_pop), 32'd0);
            tick();
            check("bp_hold_prd", p6(out_prd, 0), 32'd46);
            check("bp_hold_lrd", l5(out_lrd, 0), 32'd12);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_pop", 32'(fl_pop), 32'd1);
        tick();
        check("bp_next_prd", p6(out_prd, 0), 32'd47);
        check("bp_next_prs1", p6(out_prs1, 0), 32'd46);
        check("bp_next_lrd", l5(out_lrd, 0), 32'd13);
        check("bp_next_valid", 32'(out_valid), 32'd1);

        // Commit x9 twice (youngest 61 wins), then rename x3 while flushing with commit x3->50
        idle();
        lane(0, 1, 2, 1, 1, 1, 0);
        cm_valid = 2'b11;
        cm_lrd   = {5'd9, 5'd9};
        cm_prd   = {6'd61, 6'd60};
        tick();
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        idle();
        lane(0, 1, 1, 3, 1, 1, 1);
        pregs(44, 0);
        cm_valid    = 2'b01;
        cm_lrd      = {5'd0, 5'd3};
        cm_prd      = {6'd0, 6'd50};
        flush_valid = 1'b1;
        #1;
        check("fl_in_ready", 32'(in_ready), 32'd0);
        check("fl_fl_pop", 32'(fl_pop), 32'd0);
        tick();
        check("fl_out_valid", 32'(out_valid), 32'd0);
        idle();
        lane(0, 3, 9, 1, 1, 1, 0);
        lane(1, 5, 12, 2, 1, 1, 0);
        tick();
        check("fl_rat3", p6(out_prs1, 0), 32'd50);
        check("fl_rat9", p6(out_prs2, 0), 32'd61);
        check("fl_rat5", p6(out_prs1, 1), 32'd5);
        check("fl_rat12", p6(out_prs2, 1), 32'd12);

        // Writes to x0
        idle();
        lane(0, 1, 1, 0, 1, 1, 1);
        lane(1, 0, 2, 4, 1, 1, 1);
        pregs(52, 53);
`ifdef RENAME_ZERO_REG_EN
        #1;
        check("x0_fl_pop", 32'(fl_pop), 32'd1);
        tick();
        check("x0_prd_l0", p6(out_prd, 0), 32'd0);
        check("x0_prd_l1", p6(out_prd, 1), 32'd52);
        check("x0_prs1_l1", p6(out_prs1, 1), 32'd0);
        idle();
        lane(0, 0, 4, 1, 1, 1, 0);
        tick();
        check("x0_later_prs1", p6(out_prs1, 0), 32'd0);
        check("x0_later_prs2", p6(out_prs2, 0), 32'd52);
`else
        #1;
        check("x0_fl_pop", 32'(fl_pop), 32'd2);
        tick();
        check("x0_prd_l0", p6(out_prd, 0), 32'd52);
        check("x0_prd_l1", p6(out_prd, 1), 32'd53);
        check("x0_prs1_l1", p6(out_prs1, 1), 32'd52);
        idle();
        lane(0, 0, 4, 1, 1, 1, 0);
        tick();
        check("x0_later_prs1", p6(out_prs1, 0), 32'd52);
        check("x0_later_prs2", p6(out_prs2, 0), 32'd53);
`endif

        // Reset mid-group discards the output and restores both RATs
        idle();
        lane(0, 1, 1, 3, 1, 1, 1);
        pregs(20, 0);
        tick();
        check("mid_prd", p6(out_prd, 0), 32'd20);
        reset = 1'b1;
        #1;
        check("mid_out_valid", 32'(out_valid), 32'd0);
        check("mid_in_ready", 32'(in_ready), 32'd0);
        check("mid_out_prd", p6(out_prd, 0), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle();
        lane(0, 3, 9, 1, 1, 1, 0);
        tick();
        check("mid_rat3", p6(out_prs1, 0), 32'd3);
        check("mid_rat9", p6(out_prs2, 0), 32'd9);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
